serial_rx_core: RTL and testbench
=================================

SERIAL_RX_CORE -- requirements
Module: serial_rx_core

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal 5..9).
REQ-002 The block SHALL have parameter OVERSAMPLE, default 16, meaning tick_in pulses per bit period (even, 4..32).
REQ-003 The block SHALL have parameter PARITY_EN, default 0, meaning a parity bit follows the data when 1.
REQ-004 The block SHALL have parameter PARITY_ODD, default 0, meaning odd parity when 1 and even parity when 0.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame (1 or 2).
REQ-006 The block SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-008 The block SHALL have port tick_in  input  1  oversample strobe, one clk wide, counted only when high on a clk edge.
REQ-009 The block SHALL have port dcom  input  1  asynchronous serial line; idles high; LSB first.
REQ-010 The block SHALL have port bus  output  DATA_BITS  last received data word.
REQ-011 The block SHALL have port bus_valid  output  1  bus holds an unconsumed word.
REQ-012 The block SHALL have port bus_ready  input  1  consumer accepts the word when high with bus_valid.
REQ-013 The block SHALL have port parity_err  output  1  parity mismatch for the word on bus.
REQ-014 The block SHALL have port frame_err  output  1  a stop bit was sampled low for the word on bus.
REQ-015 The block SHALL have port overrun  output  1  one-clk pulse; a completed frame was dropped.
REQ-016 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 dcom SHALL pass through a 2-flop synchroniser (reset value 1); all decisions use the synchronised value.
REQ-018 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, and BREAK, with a tick counter and a bit counter.
REQ-019 In IDLE, a synchronised high-to-low transition SHALL move to START with the tick counter cleared.
REQ-020 In START, at the OVERSAMPLE/2-th tick the line SHALL be sampled: low -> DATA with counters cleared; high -> IDLE (false start, no output).
REQ-021 In DATA, every OVERSAMPLE-th tick SHALL sample one bit into position bit-counter (LSB first); after DATA_BITS samples -> PARITY if PARITY_EN else STOP.
REQ-022 In PARITY, the sample SHALL be compared with XOR(data) XOR PARITY_ODD; a mismatch sets the frame's parity error.
REQ-023 In STOP, each of STOP_BITS samples taken every OVERSAMPLE ticks SHALL be checked; any low sample sets the frame's framing error.
REQ-024 After the last stop sample, the frame SHALL complete: on the next clk, bus, parity_err and frame_err load together and bus_valid rises (latency 1 clk from the final sample tick).
REQ-025 After completion, the FSM SHALL go to IDLE if the last stop sample was high, else to BREAK; BREAK waits for a synchronised high before IDLE, so a held-low line never restarts.
REQ-026 bus, parity_err and frame_err SHALL remain stable while bus_valid is high; bus_valid clears on the clk after bus_valid && bus_ready.
REQ-027 If a frame completes while bus_valid is high and bus_ready is low, the new frame SHALL be discarded, bus and its flags kept, and overrun pulsed for 1 clk.
REQ-028 If a frame completes in the same clk that bus_valid && bus_ready, the new frame SHALL load, bus_valid stays high, and overrun stays low.
REQ-029 Clocks with tick_in low SHALL NOT advance any counter; the synchroniser and handshake still operate on every clk.
REQ-030 Frames with parity or framing errors SHALL still be delivered with their flags set.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, clear all counters and the data shift register, set bus=0, bus_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, and synchroniser flops to 1.
REQ-032 Reset asserted mid-frame SHALL abandon the frame with no output; after release the block waits for a fresh falling edge.

Verification
REQ-033 Defaults, tick every clk, send 0xA5 with 1 stop bit -> bus=0xA5, bus_valid=1 one clk after the stop mid-sample, errors 0.
REQ-034 Line low for 4 ticks then high -> no bus_valid, FSM back in IDLE, busy=0.
REQ-035 PARITY_EN=1, PARITY_ODD=0, send 0x07 with parity bit 0 -> bus=0x07, parity_err=1.
REQ-036 Send 0x3C with stop bit low, line held low for 40 bit times -> one frame with frame_err=1, no further frames until the line goes high.
REQ-037 Send 0x11 then 0x22 with bus_ready=0 -> bus stays 0x11, overrun pulses once; then bus_ready=1 -> bus_valid clears next clk.
REQ-038 Assert rst_n=0 during bit 3 of a frame -> all outputs 0 immediately; the next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/serial_rx_core.sv
// -----------------------------------------------------------------------------
// serial_rx_core
//
// Oversampling asynchronous serial receiver. The serial line is synchronised,
// a falling edge opens a frame, the start bit is confirmed at its midpoint and
// every following bit (data LSB first, optional parity, one or two stop bits)
// is sampled one bit period later. A completed frame is offered on a
// valid/ready output register together with its parity and framing flags.
//
// Parameters
//   DATA_BITS   data bits per frame (5..9)
//   OVERSAMPLE  tick_in pulses per bit period (even, 4..32)
//   PARITY_EN   1: a parity bit follows the data
//   PARITY_ODD  1: odd parity, 0: even parity
//   STOP_BITS   stop bits checked per frame (1 or 2)
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   tick_in     oversample strobe, one clk wide
//   dcom        asynchronous serial line, idles high
//   bus         last received data word
//   bus_valid   bus holds an unconsumed word
//   bus_ready   consumer accepts the word when high together with bus_valid
//   parity_err  parity mismatch for the word on bus
//   frame_err   a stop bit of the word on bus was sampled low
//   overrun     one-clk pulse: a completed frame was dropped
//   busy        receiver is not in IDLE
// -----------------------------------------------------------------------------
module serial_rx_core #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tick_in,
   input  logic                 dcom,
   output logic [DATA_BITS-1:0] bus,
   output logic                 bus_valid,
   input  logic                 bus_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);

   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
   localparam logic          ODD_BIT   = logic'(PARITY_ODD != 0);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } state_t;

   // Line synchroniser and previous-value flop for edge detection
   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic rx_prev_q, rx_prev_d;

   // Frame receive state
   state_t               state_q, state_d;
   logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
   logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 done_q, done_d;

   // Output register
   logic [DATA_BITS-1:0] bus_q, bus_d;
   logic                 bus_valid_q, bus_valid_d;
   logic                 parity_err_q, parity_err_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;

   logic rx;
   logic tick_last;
   logic accept;

   assign rx        = sync2_q;
   assign tick_last = (tick_cnt_q == TICK_LAST);
   assign accept    = bus_valid_q && bus_ready;

   // ---------------------------------------------------------------------------
   // Synchroniser: runs every clk regardless of tick_in
   // ---------------------------------------------------------------------------
   always_comb begin
      sync1_d   = dcom;
      sync2_d   = sync1_q;
      rx_prev_d = sync2_q;
   end

   // ---------------------------------------------------------------------------
   // Receive FSM next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a signal unassigned and infer a latch.
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      done_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            if (rx_prev_q && !rx) begin
               state_d = ST_START;
            end
         end

         ST_START: begin
            if (tick_in) begin
               if (tick_cnt_q == TICK_MID) begin
                  tick_cnt_d = '0;
                  bit_cnt_d  = '0;
                  // A start bit that is high again at its midpoint was a glitch
                  if (!rx) begin
                     state_d = ST_DATA;
                     perr_d  = 1'b0;
                     ferr_d  = 1'b0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TW'(1);
               end
            end
         end

         ST_DATA: begin
            if (tick_in) begin
               if (tick_last) begin
                  tick_cnt_d          = '0;
                  shift_d[bit_cnt_q]  = rx;
                  if (bit_cnt_q == DATA_LAST) begin
                     bit_cnt_d = '0;
                     state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BW'(1);
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TW'(1);
               end
            end
         end

         ST_PARITY: begin
            if (tick_in) begin
               if (tick_last) begin
                  tick_cnt_d = '0;
                  if (rx != ((^shift_q) ^ ODD_BIT)) begin
                     perr_d = 1'b1;
                  end
                  state_d = ST_STOP;
               end else begin
                  tick_cnt_d = tick_cnt_q + TW'(1);
               end
            end
         end

         ST_STOP: begin
            if (tick_in) begin
               if (tick_last) begin
                  tick_cnt_d = '0;
                  if (!rx) begin
                     ferr_d = 1'b1;
                  end
                  if (bit_cnt_q == STOP_LAST) begin
                     // Frame complete; a low final stop sample means the line
                     // is held in break and must return high before rearming
                     done_d    = 1'b1;
                     bit_cnt_d = '0;
                     state_d   = rx ? ST_IDLE : ST_BREAK;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BW'(1);
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TW'(1);
               end
            end
         end

         ST_BREAK: begin
            if (rx) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output register and handshake. A finished frame lands one clk after its
   // final stop sample; it is dropped only if the previous word is still held
   // and not being accepted in this same clk.
   // ---------------------------------------------------------------------------
   always_comb begin
      bus_d        = bus_q;
      bus_valid_d  = bus_valid_q;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
      overrun_d    = 1'b0;

      if (done_q) begin
         if (!bus_valid_q || accept) begin
            bus_d        = shift_q;
            parity_err_d = perr_q;
            frame_err_d  = ferr_q;
            bus_valid_d  = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (accept) begin
         bus_valid_d = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of the others. The shift register is reset
   // too, so a frame abandoned by reset leaves no stale data behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         rx_prev_q    <= 1'b1;
         state_q      <= ST_IDLE;
         tick_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         perr_q       <= 1'b0;
         ferr_q       <= 1'b0;
         done_q       <= 1'b0;
         bus_q        <= '0;
         bus_valid_q  <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         rx_prev_q    <= rx_prev_d;
         state_q      <= state_d;
         tick_cnt_q   <= tick_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         perr_q       <= perr_d;
         ferr_q       <= ferr_d;
         done_q       <= done_d;
         bus_q        <= bus_d;
         bus_valid_q  <= bus_valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign bus        = bus_q;
   assign bus_valid  = bus_valid_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_rx_core.sv
// -----------------------------------------------------------------------------
// tb_serial_rx_core
//
// Directed bench for serial_rx_core. Two instances share clk, rst_n and
// tick_in: u_dut uses the default parameters, u_dut_p enables even parity.
// Each scenario task drives its own frames and compares outputs against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_serial_rx_core;

   logic       clk;
   logic       rst_n;
   logic       tick_in;

   logic       dcom, bus_ready;
   logic [7:0] bus;
   logic       bus_valid, parity_err, frame_err, overrun, busy;

   logic       dcom_p, bus_ready_p;
   logic [7:0] bus_p;
   logic       bus_valid_p, parity_err_p, frame_err_p, overrun_p, busy_p;

   int tests_run = 0;
   int fails     = 0;
   int tick_div  = 1;
   int tick_phase = 0;

   int   ovr_cnt  = 0;
   int   rise_cnt = 0;
   logic prev_valid = 1'b0;
   logic [7:0] got_q[$];

   serial_rx_core u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_in   (tick_in),
      .dcom      (dcom),
      .bus       (bus),
      .bus_valid (bus_valid),
      .bus_ready (bus_ready),
      .parity_err(parity_err),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   serial_rx_core #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut_p (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_in   (tick_in),
      .dcom      (dcom_p),
      .bus       (bus_p),
      .bus_valid (bus_valid_p),
      .bus_ready (bus_ready_p),
      .parity_err(parity_err_p),
      .frame_err (frame_err_p),
      .overrun   (overrun_p),
      .busy      (busy_p)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Oversample strobe: one pulse every tick_div clocks
   initial begin
      tick_in = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tick_phase = (tick_phase + 1 >= tick_div) ? 0 : tick_phase + 1;
         tick_in    = (tick_phase == 0);
      end
   end

   // Event monitors for the default instance
   always @(negedge clk) begin
      if (overrun) ovr_cnt <= ovr_cnt + 1;
      if (bus_valid && !prev_valid) rise_cnt <= rise_cnt + 1;
      prev_valid <= bus_valid;
      if (bus_valid && bus_ready) got_q.push_back(bus);
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_clks(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [15:0] mk(input logic [7:0] d, input logic stop);
      return {6'b0, stop, d, 1'b0};
   endfunction

   function automatic logic [15:0] mkp(input logic [7:0] d, input logic par, input logic stop);
      return {5'b0, stop, par, d, 1'b0};
   endfunction

   // Drive n line bits LSB first, one full bit period each
   task automatic send(input int which, input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         if (which == 0) dcom = bits[i];
         else            dcom_p = bits[i];
         wait_clks(16 * tick_div);
      end
   endtask

   task automatic consume(input string name);
      bus_ready = 1'b1;
      wait_clks(1);
      bus_ready = 1'b0;
      tests_run++;
      if (bus_valid !== 1'b0) begin
         fails++;
         $display("FAIL %s_consume: bus_valid=%b expected 0", name, bus_valid);
      end
   endtask

   task automatic consume_p(input string name);
      bus_ready_p = 1'b1;
      wait_clks(1);
      bus_ready_p = 1'b0;
      tests_run++;
      if (bus_valid_p !== 1'b0) begin
         fails++;
         $display("FAIL %s_consume: bus_valid=%b expected 0", name, bus_valid_p);
      end
   endtask

   task automatic check_word(input string name, input logic [7:0] d, input logic pe, input logic fe);
      tests_run++;
      if ({bus, bus_valid, parity_err, frame_err} !== {d, 1'b1, pe, fe}) begin
         fails++;
         $display("FAIL %s: bus=%h valid=%b perr=%b ferr=%b expected bus=%h valid=1 perr=%b ferr=%b",
                  name, bus, bus_valid, parity_err, frame_err, d, pe, fe);
      end
   endtask

   // --------------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0;
      dcom = 1'b1; dcom_p = 1'b1;
      bus_ready = 1'b0; bus_ready_p = 1'b0;
      wait_clks(3);
      tests_run++;
      if ({bus, bus_valid, parity_err, frame_err, overrun, busy} !== 13'h0) begin
         fails++;
         $display("FAIL reset_held: outputs=%h expected 0",
                  {bus, bus_valid, parity_err, frame_err, overrun, busy});
      end
      tests_run++;
      if ({bus_p, bus_valid_p, parity_err_p, frame_err_p, overrun_p, busy_p} !== 13'h0) begin
         fails++;
         $display("FAIL reset_held_p: outputs=%h expected 0",
                  {bus_p, bus_valid_p, parity_err_p, frame_err_p, overrun_p, busy_p});
      end
      rst_n = 1'b1;
      wait_clks(5);
      tests_run++;
      if ({bus, bus_valid, parity_err, frame_err, overrun, busy} !== 13'h0) begin
         fails++;
         $display("FAIL reset_released: outputs=%h expected 0",
                  {bus, bus_valid, parity_err, frame_err, overrun, busy});
      end
   endtask

   // 0xA5, tick every clk: start edge reaches the FSM after the 2-flop
   // synchroniser, start midpoint 8 ticks later, then 9 more bit periods to the
   // stop midpoint, plus one clk to load the output register.
   task automatic test_basic();
      logic [15:0] bits;
      int   rise_at;
      logic busy_mid;
      bits     = mk(8'hA5, 1'b1);
      rise_at  = -1;
      busy_mid = 1'b0;
      dcom     = bits[0];
      for (int c = 1; c <= 170; c++) begin
         @(posedge clk);
         #1;
         if (bus_valid && rise_at < 0) rise_at = c;
         if (c == 50) busy_mid = busy;
         if (c % 16 == 0 && c < 160) dcom = bits[c / 16];
      end
      dcom = 1'b1;
      tests_run++;
      if (rise_at < 155 || rise_at > 157) begin
         fails++;
         $display("FAIL basic_latency: bus_valid rose at clk %0d expected 155..157", rise_at);
      end
      tests_run++;
      if (busy_mid !== 1'b1) begin
         fails++;
         $display("FAIL basic_busy: busy=%b mid-frame expected 1", busy_mid);
      end
      check_word("basic_word", 8'hA5, 1'b0, 1'b0);
      consume("basic");
      tests_run++;
      if (bus !== 8'hA5) begin
         fails++;
         $display("FAIL basic_bus_kept: bus=%h expected a5", bus);
      end
   endtask

   task automatic test_false_start();
      int rise0;
      rise0 = rise_cnt;
      dcom  = 1'b0;
      wait_clks(4);
      tests_run++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL false_start_busy: busy=%b expected 1", busy);
      end
      dcom = 1'b1;
      wait_clks(30);
      tests_run++;
      if ({busy, bus_valid} !== 2'b00 || rise_cnt != rise0) begin
         fails++;
         $display("FAIL false_start_idle: busy=%b valid=%b frames=%0d expected 0 0 0",
                  busy, bus_valid, rise_cnt - rise0);
      end
   endtask

   // Even parity: 0x07 has three ones, so the correct parity bit is 1
   task automatic test_parity();
      send(1, mkp(8'h07, 1'b0, 1'b1), 11);
      wait_clks(3);
      tests_run++;
      if ({bus_p, bus_valid_p, parity_err_p, frame_err_p} !== {8'h07, 3'b110}) begin
         fails++;
         $display("FAIL parity_bad: bus=%h valid=%b perr=%b ferr=%b expected 07 1 1 0",
                  bus_p, bus_valid_p, parity_err_p, frame_err_p);
      end
      consume_p("parity_bad");
      send(1, mkp(8'h07, 1'b1, 1'b1), 11);
      wait_clks(3);
      tests_run++;
      if ({bus_p, bus_valid_p, parity_err_p, frame_err_p} !== {8'h07, 3'b100}) begin
         fails++;
         $display("FAIL parity_good: bus=%h valid=%b perr=%b ferr=%b expected 07 1 0 0",
                  bus_p, bus_valid_p, parity_err_p, frame_err_p);
      end
      consume_p("parity_good");
   endtask

   task automatic test_break();
      int rise0, ovr0;
      rise0 = rise_cnt;
      ovr0  = ovr_cnt;
      send(0, mk(8'h3C, 1'b0), 10);
      dcom = 1'b0;
      wait_clks(40 * 16);
      check_word("break_word", 8'h3C, 1'b0, 1'b1);
      tests_run++;
      if (rise_cnt != rise0 + 1 || ovr_cnt != ovr0) begin
         fails++;
         $display("FAIL break_frames: frames=%0d overruns=%0d expected 1 0",
                  rise_cnt - rise0, ovr_cnt - ovr0);
      end
      tests_run++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL break_busy: busy=%b expected 1", busy);
      end
      dcom = 1'b1;
      wait_clks(10);
      tests_run++;
      if (busy !== 1'b0 || rise_cnt != rise0 + 1) begin
         fails++;
         $display("FAIL break_release: busy=%b frames=%0d expected 0 1", busy, rise_cnt - rise0);
      end
      consume("break");
   endtask

   task automatic test_overrun();
      int ovr0;
      ovr0 = ovr_cnt;
      send(0, mk(8'h11, 1'b1), 10);
      send(0, mk(8'h22, 1'b1), 10);
      wait_clks(4);
      check_word("overrun_word", 8'h11, 1'b0, 1'b0);
      tests_run++;
      if (ovr_cnt != ovr0 + 1) begin
         fails++;
         $display("FAIL overrun_pulses: count=%0d expected 1", ovr_cnt - ovr0);
      end
      consume("overrun");
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_words [3];
      int ovr0;
      exp_words[0] = 8'h00;
      exp_words[1] = 8'hFF;
      exp_words[2] = 8'hC3;
      ovr0 = ovr_cnt;
      got_q.delete();
      bus_ready = 1'b1;
      for (int i = 0; i < 3; i++) send(0, mk(exp_words[i], 1'b1), 10);
      wait_clks(4);
      bus_ready = 1'b0;
      tests_run++;
      if (got_q.size() != 3 || ovr_cnt != ovr0) begin
         fails++;
         $display("FAIL b2b_count: words=%0d overruns=%0d expected 3 0",
                  got_q.size(), ovr_cnt - ovr0);
      end else begin
         for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (got_q[i] !== exp_words[i]) begin
               fails++;
               $display("FAIL b2b_word%0d: got %h expected %h", i, got_q[i], exp_words[i]);
            end
         end
      end
   endtask

   task automatic test_tick_gap();
      tick_div = 3;
      wait_clks(6);
      send(0, mk(8'h96, 1'b1), 10);
      wait_clks(6);
      check_word("tick_gap_word", 8'h96, 1'b0, 1'b0);
      consume("tick_gap");
      tick_div = 1;
      wait_clks(4);
   endtask

   task automatic test_reset_midframe();
      logic [7:0] d;
      int rise0;
      send(0, mk(8'h33, 1'b1), 10);
      wait_clks(2);
      d    = 8'h5A;
      dcom = 1'b0;
      wait_clks(16);
      for (int i = 0; i < 3; i++) begin
         dcom = d[i];
         wait_clks(16);
      end
      dcom = d[3];
      wait_clks(8);
      tests_run++;
      if ({bus_valid, busy} !== 2'b11) begin
         fail_pre: begin
            fails++;
            $display("FAIL midreset_pre: valid=%b busy=%b expected 1 1", bus_valid, busy);
         end
      end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({bus, bus_valid, parity_err, frame_err, overrun, busy} !== 13'h0) begin
         fails++;
         $display("FAIL midreset_outputs: outputs=%h expected 0",
                  {bus, bus_valid, parity_err, frame_err, overrun, busy});
      end
      dcom = 1'b1;
      wait_clks(3);
      rst_n = 1'b1;
      wait_clks(5);
      rise0 = rise_cnt;
      send(0, mk(8'h5A, 1'b1), 10);
      wait_clks(3);
      check_word("midreset_word", 8'h5A, 1'b0, 1'b0);
      tests_run++;
      if (rise_cnt != rise0 + 1) begin
         fails++;
         $display("FAIL midreset_frames: frames=%0d expected 1", rise_cnt - rise0);
      end
      consume("midreset");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_false_start();
      test_parity();
      test_break();
      test_overrun();
      test_back_to_back();
      test_tick_gap();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
